// File: rtl/bd_pkg.sv
// Shared types and helpers for the bundled-data pipeline buffer.
package bd_pkg;

  // Left (producer-facing) handshake states.
  typedef enum logic {
    L_IDLE = 1'b0,
    L_ACK  = 1'b1
  } l_state_t;

  // Right (consumer-facing) handshake states.
  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_FWD  = 3'd1,
    R_REQ  = 3'd2,
    R_RTZ  = 3'd3,
    R_BL   = 3'd4
  } r_state_t;

  // Circular pointer increment that works for any depth, not just powers of two.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/bd_pipeline_buffer_if.sv
// Both 4-phase bundled-data channels of the buffer, grouped as one bus.
// master = the environment (producer + consumer), slave = the buffer.
interface bd_pipeline_buffer_if #(
  parameter int WIDTH = 8
);
  logic             l_req;
  logic [WIDTH-1:0] l_data;
  logic             l_ack;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;

  modport master (
    output l_req, l_data, r_ack,
    input  l_ack, r_req, r_data
  );

  modport slave (
    input  l_req, l_data, r_ack,
    output l_ack, r_req, r_data
  );
endinterface

// File: rtl/bd_fifo_core.sv
// Circular token store: push at wr_ptr, pop at rd_ptr, head is the oldest entry.
module bd_fifo_core
  import bd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [PTR_W-1:0] w_rd_ptr_inc;

  assign w_full    = (r_count == OCC_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A pop frees the slot on the same edge, so a push is allowed at full only alongside it.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign w_wr_ptr_inc = PTR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
  assign w_rd_ptr_inc = PTR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));

  // Token storage write; no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_occupancy = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

endmodule

// File: rtl/bd_pipeline_buffer.sv
// Clocked model of a 4-phase bundled-data pipeline stage with FIFO storage,
// programmable forward latency (FL) and backward (reset-to-zero) latency (BL).
module bd_pipeline_buffer
  import bd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int FL    = 2,
  parameter int BL    = 6,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bd_pipeline_buffer_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam int MAXL  = (FL > BL) ? FL : BL;
  localparam int LAT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

  l_state_t         r_lstate;
  l_state_t         w_lstate_nxt;
  r_state_t         r_rstate;
  r_state_t         w_rstate_nxt;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_lat_nxt;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] w_rdata_nxt;
  logic [CNT_W-1:0] r_xfer;
  logic [CNT_W-1:0] w_xfer_nxt;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;

  assign w_push = (r_lstate == L_IDLE) && bus.l_req && !w_full;
  assign w_pop  = (r_rstate == R_REQ) && bus.r_ack;

  bd_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (bus.l_data),
    .o_head      (w_head),
    .o_occupancy (occupancy),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // State, latency counter, output data latch and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lstate <= L_IDLE;
      r_rstate <= R_IDLE;
      r_lat    <= '0;
      r_rdata  <= '0;
      r_xfer   <= '0;
    end else begin
      r_lstate <= w_lstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_lat    <= w_lat_nxt;
      r_rdata  <= w_rdata_nxt;
      r_xfer   <= w_xfer_nxt;
    end
  end

  // Left FSM: accept one token per full 4-phase cycle while space exists.
  always_comb begin
    w_lstate_nxt = r_lstate;
    case (r_lstate)
      L_IDLE:  if (w_push) w_lstate_nxt = L_ACK;
      L_ACK:   if (!bus.l_req) w_lstate_nxt = L_IDLE;
      default: w_lstate_nxt = L_IDLE;
    endcase
  end

  // Right FSM: wait FL, offer the head, pop on ack, wait for ack release, then BL.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_lat_nxt    = r_lat;
    w_rdata_nxt  = r_rdata;
    w_xfer_nxt   = r_xfer;
    case (r_rstate)
      R_IDLE: begin
        if (!w_empty) begin
          if (FL == 0) begin
            w_rstate_nxt = R_REQ;
            w_rdata_nxt  = w_head;
          end else begin
            w_rstate_nxt = R_FWD;
            w_lat_nxt    = LAT_W'(FL - 1);
          end
        end
      end
      R_FWD: begin
        if (r_lat == '0) begin
          w_rstate_nxt = R_REQ;
          w_rdata_nxt  = w_head;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      R_REQ: begin
        if (bus.r_ack) begin
          w_rstate_nxt = R_RTZ;
          w_xfer_nxt   = r_xfer + CNT_W'(1);
        end
      end
      R_RTZ: begin
        if (!bus.r_ack) begin
          if (BL == 0) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rstate_nxt = R_BL;
            w_lat_nxt    = LAT_W'(BL - 1);
          end
        end
      end
      R_BL: begin
        if (r_lat == '0) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_data comes from a register loaded on entry to R_REQ, so it holds while r_req is high.
  assign bus.l_ack  = (r_lstate == L_ACK);
  assign bus.r_req  = (r_rstate == R_REQ);
  assign bus.r_data = r_rdata;
  assign full       = w_full;
  assign empty      = w_empty;
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_bd_pipeline_buffer.sv
// Directed bench: instance A uses the defaults (DEPTH=4, FL=2, BL=6, CNT_W=16),
// instance B is DEPTH=3, FL=0, BL=0, CNT_W=4 for wrap, order and counter rollover.
module tb_bd_pipeline_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;

  bd_pipeline_buffer_if #(.WIDTH(8)) if_a ();
  bd_pipeline_buffer_if #(.WIDTH(8)) if_b ();

  logic [2:0]  occ_a;
  logic        full_a, empty_a;
  logic [15:0] xfer_a;
  logic [1:0]  occ_b;
  logic        full_b, empty_b;
  logic [3:0]  xfer_b;

  bd_pipeline_buffer #(.WIDTH(8), .DEPTH(4), .FL(2), .BL(6), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(if_a),
    .occupancy(occ_a), .full(full_a), .empty(empty_a), .xfer_count(xfer_a)
  );

  bd_pipeline_buffer #(.WIDTH(8), .DEPTH(3), .FL(0), .BL(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(if_b),
    .occupancy(occ_b), .full(full_b), .empty(empty_b), .xfer_count(xfer_b)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       exp_ack;
    logic [2:0] exp_occ;
    logic       exp_full;
  } fill_vec_t;

  fill_vec_t fv [5];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, want DUT event", name);
  endtask

  // 0: A l_ack, 1: A r_req, 2: B l_ack, 3: B r_req
  function automatic logic sig_of(input int which);
    case (which)
      0:       return if_a.l_ack;
      1:       return if_a.r_req;
      2:       return if_b.l_ack;
      default: return if_b.r_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl, input int budget,
                          input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig_of(which) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire(name);
  endtask

  task automatic set_lreq(input int side, input logic v, input logic [7:0] d);
    if (side == 0) begin if_a.l_req = v; if_a.l_data = d; end
    else           begin if_b.l_req = v; if_b.l_data = d; end
  endtask

  task automatic set_rack(input int side, input logic v);
    if (side == 0) if_a.r_ack = v;
    else           if_b.r_ack = v;
  endtask

  // Full left 4-phase cycle; called and returns on a falling clock edge.
  task automatic send(input int side, input logic [7:0] d);
    bit ok;
    set_lreq(side, 1'b1, d);
    wait_for(2 * side, 1'b1, 60, $sformatf("side%0d l_ack rise", side), ok);
    set_lreq(side, 1'b0, d);
    wait_for(2 * side, 1'b0, 5, $sformatf("side%0d l_ack fall", side), ok);
  endtask

  // Full right 4-phase cycle with an optional delay before acking.
  task automatic recv(input int side, input int dly, output logic [7:0] d);
    bit ok;
    wait_for(2 * side + 1, 1'b1, 80, $sformatf("side%0d r_req rise", side), ok);
    repeat (dly) @(negedge clk);
    d = (side == 0) ? if_a.r_data : if_b.r_data;
    set_rack(side, 1'b1);
    wait_for(2 * side + 1, 1'b0, 5, $sformatf("side%0d r_req fall", side), ok);
    set_rack(side, 1'b0);
  endtask

  task automatic reset_dut(input int side);
    @(negedge clk);
    if (side == 0) rst_a_n = 1'b0; else rst_b_n = 1'b0;
    repeat (2) @(negedge clk);
    if (side == 0) rst_a_n = 1'b1; else rst_b_n = 1'b1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " l_ack"},      if_a.l_ack,  0);
    chk({tag, " r_req"},      if_a.r_req,  0);
    chk({tag, " occupancy"},  occ_a,       0);
    chk({tag, " empty"},      empty_a,     1);
    chk({tag, " full"},       full_a,      0);
    chk({tag, " xfer_count"}, xfer_a,      0);
    chk({tag, " r_data"},     if_a.r_data, 0);
  endtask

  // A token pushed into an empty A with an idle right side: r_req after FL+1 = 3 edges.
  task automatic a_latency(input logic [7:0] d, input string tag);
    set_lreq(0, 1'b1, d);
    @(negedge clk);
    chk({tag, " l_ack 1 cycle after l_req"}, if_a.l_ack, 1);
    chk({tag, " occupancy after push"}, occ_a, 1);
    set_lreq(0, 1'b0, d);
    @(negedge clk);
    chk({tag, " r_req push+1"}, if_a.r_req, 0);
    @(negedge clk);
    chk({tag, " r_req push+2"}, if_a.r_req, 0);
    @(negedge clk);
    chk({tag, " r_req push+3"}, if_a.r_req, 1);
    chk({tag, " r_data at r_req"}, if_a.r_data, 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         cyc;
    bit         got;
    bit         ok;
    bit         fifth_ok;
    bit         done;
    logic       prev_lack, prev_rreq;
    logic [1:0] prev_occ;

    fv[0] = '{data: 8'h00, exp_ack: 1'b1, exp_occ: 3'd1, exp_full: 1'b0};
    fv[1] = '{data: 8'h01, exp_ack: 1'b1, exp_occ: 3'd2, exp_full: 1'b0};
    fv[2] = '{data: 8'h02, exp_ack: 1'b1, exp_occ: 3'd3, exp_full: 1'b0};
    fv[3] = '{data: 8'h03, exp_ack: 1'b1, exp_occ: 3'd4, exp_full: 1'b1};
    fv[4] = '{data: 8'h04, exp_ack: 1'b0, exp_occ: 3'd4, exp_full: 1'b1};

    if_a.l_req = 1'b0; if_a.l_data = '0; if_a.r_ack = 1'b0;
    if_b.l_req = 1'b0; if_b.l_data = '0; if_b.r_ack = 1'b0;

    // Asynchronous reset takes effect before the first clock edge.
    #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
    #1 chk_reset_a("power-up reset");
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Single token latency, then backward latency before the next offer.
    a_latency(8'hA5, "single");
    set_rack(0, 1'b1);
    @(negedge clk);
    chk("single r_req drops on r_ack", if_a.r_req, 0);
    chk("single xfer_count", xfer_a, 1);
    chk("single empty after pop", empty_a, 1);
    set_rack(0, 1'b0);
    cyc = 0;
    fork
      send(0, 8'h5A);
      begin
        while (!if_a.r_req && cyc < 60) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    chk("next r_req at least BL cycles after r_ack falls", 32'(cyc >= 6), 1);
    recv(0, 0, d);
    chk("second token data", d, 8'h5A);

    // Fill A with the right side stalled, then release it.
    reset_dut(0);
    for (int i = 0; i < 5; i++) begin
      set_lreq(0, 1'b1, fv[i].data);
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (if_a.l_ack) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("fill[%0d] l_ack", i), got, fv[i].exp_ack);
      chk($sformatf("fill[%0d] occupancy", i), occ_a, fv[i].exp_occ);
      chk($sformatf("fill[%0d] full", i), full_a, fv[i].exp_full);
      if (got) begin
        set_lreq(0, 1'b0, fv[i].data);
        wait_for(0, 1'b0, 5, "fill l_ack fall", ok);
      end
    end
    chk("fill r_req offered", if_a.r_req, 1);
    chk("fill head r_data", if_a.r_data, 8'h00);
    fifth_ok = 1'b0;
    fork
      begin
        wait_for(0, 1'b1, 60, "fifth l_ack", fifth_ok);
        set_lreq(0, 1'b0, 8'h04);
        wait_for(0, 1'b0, 5, "fifth l_ack fall", ok);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          recv(0, 0, d);
          chk($sformatf("drain[%0d]", k), d, 32'(k));
        end
      end
    join
    chk("fifth token acked after release", fifth_ok, 1);
    chk("drain empty", empty_a, 1);
    chk("drain xfer_count", xfer_a, 5);

    // Reset with two tokens held and r_req high.
    send(0, 8'h71);
    send(0, 8'h72);
    wait_for(1, 1'b1, 40, "mid-op r_req", ok);
    chk("mid-op occupancy", occ_a, 2);
    chk("mid-op r_req", if_a.r_req, 1);
    #2 rst_a_n = 1'b0;
    #1 chk_reset_a("mid-op reset");
    @(negedge clk);
    rst_a_n = 1'b1;
    a_latency(8'h3C, "post-reset");
    recv(0, 0, d);
    chk("post-reset token", d, 8'h3C);
    chk("post-reset empty", empty_a, 1);

    // B: push and pop on the same edge keep occupancy constant.
    send(1, 8'h11);
    wait_for(3, 1'b1, 10, "simul r_req", ok);
    chk("simul occupancy before", occ_b, 1);
    set_lreq(1, 1'b1, 8'h22);
    set_rack(1, 1'b1);
    @(negedge clk);
    chk("simul l_ack", if_b.l_ack, 1);
    chk("simul r_req dropped", if_b.r_req, 0);
    chk("simul occupancy after", occ_b, 1);
    chk("simul xfer_count", xfer_b, 1);
    set_lreq(1, 1'b0, 8'h22);
    set_rack(1, 1'b0);
    recv(1, 0, d);
    chk("simul second token", d, 8'h22);

    // B: ten tokens through DEPTH=3 with random producer/consumer gaps.
    done = 1'b0;
    prev_lack = if_b.l_ack;
    prev_rreq = if_b.r_req;
    prev_occ  = occ_b;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 10; i++) begin
              repeat ($urandom_range(0, 2)) @(negedge clk);
              send(1, 8'(i));
            end
          end
          begin
            for (int i = 0; i < 10; i++) begin
              recv(1, int'($urandom_range(0, 3)), d);
              chk($sformatf("order[%0d]", i), d, 32'(i));
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (if_b.l_ack && !prev_lack && !if_b.r_req && prev_rreq)
            chk("random simul push/pop occupancy", occ_b, prev_occ);
          prev_lack = if_b.l_ack;
          prev_rreq = if_b.r_req;
          prev_occ  = occ_b;
        end
      end
    join
    @(negedge clk);
    chk("random phase empty", empty_b, 1);
    chk("random phase not full", full_b, 0);

    // B: 4-bit transfer counter rolls over silently.
    reset_dut(1);
    for (int k = 0; k < 17; k++) begin
      send(1, 8'(k));
      recv(1, 0, d);
      chk($sformatf("wrap token %0d", k), d, 32'(k));
      chk($sformatf("xfer_count after %0d", k + 1), xfer_b, 32'((k + 1) % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bd_pipeline_buffer.md
BD_PIPELINE_BUFFER -- requirements
Module: bd_pipeline_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per token.
REQ-002 SHALL have parameter DEPTH, default 4 (>=1): token storage entries.
REQ-003 SHALL have parameter FL, default 2: forward latency, in clock cycles.
REQ-004 SHALL have parameter BL, default 6: backward latency, in clock cycles after the right handshake completes.
REQ-005 SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port l_req, input, 1: left 4-phase bundled-data request.
REQ-009 SHALL have port l_data, input, WIDTH: left data, valid while l_req is high.
REQ-010 SHALL have port l_ack, output, 1: left acknowledge.
REQ-011 SHALL have port r_req, output, 1: right 4-phase bundled-data request.
REQ-012 SHALL have port r_data, output, WIDTH: right data, stable while r_req is high.
REQ-013 SHALL have port r_ack, input, 1: right acknowledge.
REQ-014 SHALL have port occupancy, output, $clog2(DEPTH+1): entries held.
REQ-015 SHALL have ports full and empty, output, 1 each: occupancy==DEPTH and occupancy==0.
REQ-016 SHALL have port xfer_count, output, CNT_W: completed right-side transfers.

Function
REQ-017 Left FSM SHALL have states L_IDLE and L_ACK.
REQ-018 Push rule: in L_IDLE with l_req=1 and full=0, at the edge, store l_data at wr_ptr, set l_ack=1, enter L_ACK.
REQ-019 L_IDLE with l_req=1 and full=1 SHALL hold l_ack=0 with no push until space frees.
REQ-020 In L_ACK, l_req=0 SHALL clear l_ack at the next edge and return to L_IDLE.
REQ-021 Right FSM SHALL have states R_IDLE, R_FWD, R_REQ, R_RTZ and R_BL.
REQ-022 r_req SHALL rise exactly FL+1 cycles after the push edge of a token that becomes head of an empty buffer; FL=0 bypasses R_FWD.
REQ-023 r_data SHALL equal the head entry and SHALL NOT change while r_req=1.
REQ-024 In R_REQ, r_ack=1 SHALL clear r_req, pop the head, increment xfer_count and enter R_RTZ.
REQ-025 In R_RTZ, r_ack=0 SHALL enter R_BL; the FSM SHALL stay BL cycles in R_BL, then return to R_IDLE; BL=0 bypasses R_BL.
REQ-026 A push and a pop on the same edge SHALL leave occupancy unchanged, including when full.
REQ-027 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of two.
REQ-028 Token order SHALL be strictly FIFO; no token SHALL be dropped or duplicated.
REQ-029 xfer_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-030 rst_n=0 SHALL immediately force l_ack=0, r_req=0, occupancy=0, empty=1, full=0, xfer_count=0, pointers=0, FSMs to L_IDLE and R_IDLE, and r_data=0.
REQ-031 Reset mid-handshake SHALL discard all stored tokens; the first edge after rst_n rises SHALL behave as from power-up.

Structure
REQ-032 Package bd_pkg SHALL hold the left and right state enums and a ptr_inc(ptr, depth) wrap function.
REQ-033 Storage and pointers SHALL be in sub-module bd_fifo_core (push, pop, head data, occupancy); the handshake FSMs and latency counters SHALL be in bd_pipeline_buffer.

Verification
REQ-034 Reset: rst_n=0 at any time -> all REQ-030 values within the same cycle, with no clock edge needed.
REQ-035 Single token, FL=2, BL=6, l_data=8'hA5 -> l_ack high 1 cycle after l_req; r_req high 3 cycles after the push edge with r_data=8'hA5; after r_ack, the next r_req is no earlier than 6 cycles after r_ack falls.
REQ-036 Fill, DEPTH=4, r_ack tied 0, send 8'h00..8'h04 -> first four acked, occupancy=4, full=1, fifth l_req unacked; releasing the right side then acks the fifth.
REQ-037 Wrap and order, DEPTH=3, 10 tokens 0..9 with a random-delay right responder -> output sequence 0..9 exactly; simultaneous push/pop edges keep occupancy constant.
REQ-038 Reset mid-operation, occupancy=2 with r_req=1 -> pulse rst_n -> r_req=0 and empty=1; the next token is delivered with the REQ-022 latency.
REQ-039 Counter wrap, CNT_W=4, 17 transfers -> xfer_count reads 15 after the 15th transfer, 0 after the 16th, and 1 after the 17th.
